// File: rtl/rs_flag_pkg.sv
// Shared types and constants for the rs_flag_driver slice.
package rs_flag_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SET      = 3'd1,
        WAIT_SET = 3'd2,
        FULL     = 3'd3,
        CLR      = 3'd4,
        WAIT_CLR = 3'd5
    } rs_state_t;

    // Width of the FULL dwell timer used by the optional forced clear.
    localparam int TIMEOUT_W = 16;

    // Largest value a w-bit pending counter can hold.
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/rs_flag_event_cnt.sv
// Saturating up/down counter of queued events. inc and dec in the same
// cycle cancel. An inc at full scale is dropped and latches ovf_sticky
// until reset; the count never wraps.
module rs_flag_event_cnt
    import rs_flag_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             ovf_sticky
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             ovf_reg;
    logic             ovf_next;
    logic             full;

    assign full = (count_reg == CNT_MAX);

    // Next count: cancel simultaneous inc/dec, saturate at both ends.
    always_comb begin
        count_next = count_reg;
        ovf_next   = ovf_reg;
        if (inc && !dec) begin
            if (full) begin
                ovf_next = 1'b1;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end else if (dec && !inc && (count_reg != '0)) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Count and sticky overflow registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign count      = count_reg;
    assign ovf_sticky = ovf_reg;

endmodule

// File: rtl/rs_flag_driver.sv
// Driver for a set/reset status flag flop. Turns producer event pulses and
// consumer take pulses into single-cycle, mutually exclusive s/r pulses,
// queuing events that arrive while the flag is busy.
// Optional feature: define RS_FLAG_DRIVER_TIMEOUT_EN to force a clear (and
// a timeout pulse) when the flag has sat in FULL for TIMEOUT cycles.
module rs_flag_driver
    import rs_flag_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             evt,
    input  logic             take,
    input  logic             flag_q,
    output logic             s,
    output logic             r,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             ovf,
    output logic             timeout
);

    rs_state_t        state_reg;
    rs_state_t        state_next;
    logic             s_reg;
    logic             r_reg;
    logic             timeout_reg;
    logic             timeout_fire;
    logic             to_hit;
    logic             leave_idle;
    logic             cnt_inc;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_count;
    logic             cnt_ovf;

`ifdef RS_FLAG_DRIVER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt_reg;

    // Dwell timer: counts cycles spent in FULL, restarts on each FULL entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_reg <= '0;
        end else if ((state_reg == FULL) && (state_next == FULL)) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end else begin
            to_cnt_reg <= '0;
        end
    end

    assign to_hit = (state_reg == FULL) && (to_cnt_reg == TIMEOUT_W'(TIMEOUT - 1));
`else
    // No dwell timer: only an illegal TIMEOUT of 0 could make this true,
    // so FULL waits for take (or an external clear) indefinitely.
    assign to_hit = (TIMEOUT == 0);
`endif

    // Next-state logic; external clear in FULL beats take, take beats timeout.
    always_comb begin
        state_next   = state_reg;
        timeout_fire = 1'b0;
        case (state_reg)
            IDLE: begin
                if ((cnt_count != '0) || evt) begin
                    state_next = SET;
                end
            end
            SET: begin
                state_next = WAIT_SET;
            end
            WAIT_SET: begin
                // A take landing on the cycle the flag is seen high is honoured.
                if (flag_q) begin
                    state_next = take ? CLR : FULL;
                end
            end
            FULL: begin
                if (!flag_q) begin
                    state_next = IDLE;
                end else if (take) begin
                    state_next = CLR;
                end else if (to_hit) begin
                    state_next   = CLR;
                    timeout_fire = 1'b1;
                end
            end
            CLR: begin
                state_next = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (!flag_q) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // An evt arriving in IDLE with nothing queued is delivered directly.
    assign leave_idle = (state_reg == IDLE) && (state_next == SET);
    assign cnt_dec    = leave_idle && (cnt_count != '0);
    assign cnt_inc    = evt && !(leave_idle && (cnt_count == '0));

    rs_flag_event_cnt #(
        .CNT_W (CNT_W)
    ) u_event_cnt (
        .clk        (clk),
        .reset      (reset),
        .inc        (cnt_inc),
        .dec        (cnt_dec),
        .count      (cnt_count),
        .ovf_sticky (cnt_ovf)
    );

    // State and registered pulse outputs; s/r decode from disjoint states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            s_reg       <= 1'b0;
            r_reg       <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            s_reg       <= (state_next == SET);
            r_reg       <= (state_next == CLR);
            timeout_reg <= timeout_fire;
        end
    end

    assign s       = s_reg;
    assign r       = r_reg;
    assign timeout = timeout_reg;
    assign pending = cnt_count;
    assign ovf     = cnt_ovf;
    assign busy    = (state_reg != IDLE) || (cnt_count != '0);

endmodule

// File: tb/tb_rs_flag_driver.sv
// Self-checking bench for rs_flag_driver: directed scenarios plus random
// evt/take traffic, all checked every cycle against a timeline model.
module tb_rs_flag_driver;

    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 8;
    localparam int MAXQ    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             evt;
    logic             take;
    logic             flag_q;
    logic             ext_clr;
    logic             s;
    logic             r;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             ovf;
    logic             timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: episode timeline in absolute cycle numbers.
    int m_queued;
    bit m_ovf;
    bit m_in_ep;
    int m_s_at;
    int m_r_at;
    int m_to_at;
    int m_take_from;
    int m_idle_from;

    rs_flag_driver #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .evt     (evt),
        .take    (take),
        .flag_q  (flag_q),
        .s       (s),
        .r       (r),
        .pending (pending),
        .busy    (busy),
        .ovf     (ovf),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Behavioural flag flop, with an external clear hook.
    always @(posedge clk or negedge reset) begin
        if (!reset)       flag_q <= 1'b0;
        else if (ext_clr) flag_q <= 1'b0;
        else if (s)       flag_q <= 1'b1;
        else if (r)       flag_q <= 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_queued    = 0;
        m_ovf       = 1'b0;
        m_in_ep     = 1'b0;
        m_s_at      = -1;
        m_r_at      = -1;
        m_to_at     = -1;
        m_take_from = -1;
        m_idle_from = 0;
    endtask

    task automatic q_add();
        if (m_queued == MAXQ) m_ovf = 1'b1;
        else                  m_queued++;
    endtask

    // Flag is cleared by r on the next cycle; driver is idle 3 cycles on.
    task automatic m_clear(input bit by_timeout);
        m_in_ep     = 1'b0;
        m_r_at      = cyc + 1;
        m_idle_from = cyc + 3;
        if (by_timeout) m_to_at = cyc + 1;
    endtask

    task automatic model_update(input bit e, input bit tk);
        int full_from;
        if (!m_in_ep) begin
            if ((cyc >= m_idle_from) && ((m_queued > 0) || e)) begin
                m_in_ep     = 1'b1;
                m_s_at      = cyc + 1;
                m_take_from = cyc + 2;
                if ((m_queued > 0) && !e) m_queued--;
            end else if (e) begin
                q_add();
            end
        end else begin
            full_from = m_take_from + 1;
            if ((cyc == m_take_from) && tk) begin
                m_clear(1'b0);
            end else if (cyc >= full_from) begin
                if (!flag_q) begin
                    m_in_ep     = 1'b0;
                    m_idle_from = cyc + 1;
                end else if (tk) begin
                    m_clear(1'b0);
                end
`ifdef RS_FLAG_DRIVER_TIMEOUT_EN
                else if ((cyc - full_from) == (TIMEOUT - 1)) begin
                    m_clear(1'b1);
                end
`endif
            end
            if (e) q_add();
        end
    endtask

    // One clock cycle: drive, compare at negedge, then advance the model.
    task automatic step(input bit e, input bit tk, input bit xc);
        bit busy_exp;
        @(posedge clk);
        #1;
        cyc++;
        evt     = e;
        take    = tk;
        ext_clr = xc;
        @(negedge clk);
        busy_exp = m_in_ep || (cyc < m_idle_from) || (m_queued != 0);
        check("s", s, 32'(cyc == m_s_at));
        check("r", r, 32'(cyc == m_r_at));
        check("s_and_r", 32'(s & r), 0);
        check("pending", pending, m_queued);
        check("ovf", ovf, m_ovf);
        check("busy", busy, busy_exp);
        check("timeout", timeout, 32'(cyc == m_to_at));
        model_update(e, tk);
    endtask

    task automatic reach_full();
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) step(1'b0, flag_q, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s_cnt;
        int r_cnt;
        int to_cnt;

        reset = 1'b0; evt = 1'b0; take = 1'b0; ext_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_s", s, 0);
        check("rst_r", r, 0);
        check("rst_pending", pending, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b1;

        // Single evt at k=10, take at k=20.
        for (int k = 1; k <= 30; k++) begin
            step(k == 10, k == 20, 1'b0);
            if (k == 11) check("sc1_s_at_11", s, 1);
            if (k == 12) check("sc1_flag_at_12", flag_q, 1);
            if (k == 21) check("sc1_r_at_21", r, 1);
            if (k == 22) check("sc1_flag_clr_22", flag_q, 0);
            check("sc1_pending", pending, 0);
        end
        $display("scenario single_event done at cycle %0d", cyc);

        // Three events queued while FULL, then one set per take.
        reach_full();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("sc2_pending3", pending, 3);
        s_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, flag_q, 1'b0);
            if (s) s_cnt++;
        end
        check("sc2_sets", s_cnt, 3);
        check("sc2_pending0", pending, 0);
        $display("scenario queue_three done at cycle %0d", cyc);

        // Reset pulse while s is high with two events still queued.
        reach_full();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20 && !s; i++) step(1'b0, 1'b0, 1'b0);
        check("rst_s_seen", s, 1);
        check("rst_pending2", pending, 2);
        reset = 1'b0;
        #1;
        check("rst_mid_s", s, 0);
        check("rst_mid_r", r, 0);
        check("rst_mid_pending", pending, 0);
        check("rst_mid_busy", busy, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        drain(10);
        $display("scenario reset_mid_pulse done at cycle %0d", cyc);

        // Saturation: five events while FULL with a 2-bit counter.
        reach_full();
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 4) check("sat_ovf_before_4th", ovf, 0);
        end
        step(1'b0, 1'b0, 1'b0);
        check("sat_pending", pending, MAXQ);
        check("sat_ovf", ovf, 1);
        s_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, flag_q, 1'b0);
            if (s) s_cnt++;
        end
        check("sat_sets", s_cnt, MAXQ);
        $display("scenario saturate done at cycle %0d", cyc);

        // External clear while FULL: back to IDLE with no r pulse.
        reach_full();
        step(1'b0, 1'b0, 1'b1);
        r_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (r) r_cnt++;
        end
        check("xclr_no_r", r_cnt, 0);
        check("xclr_busy", busy, 0);
        $display("scenario external_clear done at cycle %0d", cyc);

        // evt and take together in FULL: r next cycle, s three cycles later.
        reach_full();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("same_r", r, 1);
        step(1'b0, 1'b0, 1'b0);
        check("same_no_s_2", s, 0);
        step(1'b0, 1'b0, 1'b0);
        check("same_no_s_3", s, 0);
        step(1'b0, 1'b0, 1'b0);
        check("same_s_4", s, 1);
        drain(15);
        $display("scenario evt_take_same_cycle done at cycle %0d", cyc);

        // Hold the flag for 100 cycles without take.
        step(1'b1, 1'b0, 1'b0);
        to_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (timeout) to_cnt++;
        end
`ifdef RS_FLAG_DRIVER_TIMEOUT_EN
        check("hold_timeouts", to_cnt, 1);
        check("hold_flag", flag_q, 0);
`else
        check("hold_timeouts", to_cnt, 0);
        check("hold_flag", flag_q, 1);
`endif
        drain(10);
        $display("scenario hold_100 done at cycle %0d", cyc);

        // Random evt/take traffic.
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30, 1'b0);
        end
        drain(40);
        $display("scenario random_10k done at cycle %0d", cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
